// File: rtl/csa_seq_multiplier.sv
// Iterative tagged multiplier: folds PP_PER_CYCLE partial products per cycle into a
// carry-save sum/carry pair, then resolves with a single carry-propagate add.
module csa_seq_multiplier #(
    parameter int WIDTH        = 32,
    parameter int PP_PER_CYCLE = 4,
    parameter int TAG_W        = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy
);
    localparam int ITER  = WIDTH / PP_PER_CYCLE;
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(ITER + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [PW-1:0]      a_sh_reg;
    logic [WIDTH:0]     b_sh_reg;
    logic [PW-1:0]      sum_reg, carry_reg;
    logic               neg_reg;
    logic [TAG_W-1:0]   tag_hold_reg;
    logic [PW-1:0]      product_reg;
    logic [TAG_W-1:0]   tag_out_reg;

    logic               accept;
    logic               a_neg, b_neg;
    logic [WIDTH:0]     a_ext, b_ext, a_mag, b_mag;
    logic [PW-1:0]      cpa_sum, resolved;
    logic [PW-1:0]      sum_next, carry_next;

    assign in_ready    = (state_reg == IDLE);
    assign out_valid   = (state_reg == DONE);
    assign busy        = (state_reg != IDLE);
    assign out_product = product_reg;
    assign out_tag     = tag_out_reg;
    assign accept      = in_valid & in_ready & ~flush;

    // One extra magnitude bit so that -2^(WIDTH-1) negates without overflow
    assign a_neg = in_signed & in_a[WIDTH-1];
    assign b_neg = in_signed & in_b[WIDTH-1];
    assign a_ext = {a_neg, in_a};
    assign b_ext = {b_neg, in_b};
    assign a_mag = a_neg ? -a_ext : a_ext;
    assign b_mag = b_neg ? -b_ext : b_ext;

    // 3:2 compressor chain: each stage absorbs one partial product, no word-wide carry
    genvar gi;
    generate
        for (gi = 0; gi < PP_PER_CYCLE; gi++) begin : g_csa
            logic [PW-1:0] s_in, c_in, pp, s_out, c_out;
            if (gi == 0) begin : g_first
                assign s_in = sum_reg;
                assign c_in = carry_reg;
            end else begin : g_next
                assign s_in = g_csa[gi-1].s_out;
                assign c_in = g_csa[gi-1].c_out;
            end
            assign pp    = b_sh_reg[gi] ? (a_sh_reg << gi) : '0;
            assign s_out = s_in ^ c_in ^ pp;
            assign c_out = ((s_in & c_in) | (s_in & pp) | (c_in & pp)) << 1;
        end
    endgenerate

    assign sum_next   = g_csa[PP_PER_CYCLE-1].s_out;
    assign carry_next = g_csa[PP_PER_CYCLE-1].c_out;
    assign cpa_sum    = sum_reg + carry_reg;
    assign resolved   = neg_reg ? -cpa_sum : cpa_sum;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = ACCUM;
            ACCUM:   if (cnt_reg == CNT_W'(ITER - 1)) state_next = RESOLVE;
            RESOLVE: state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            a_sh_reg     <= '0;
            b_sh_reg     <= '0;
            sum_reg      <= '0;
            carry_reg    <= '0;
            neg_reg      <= 1'b0;
            tag_hold_reg <= '0;
            product_reg  <= '0;
            tag_out_reg  <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: if (accept) begin
                    a_sh_reg     <= {{(WIDTH-1){1'b0}}, a_mag};
                    b_sh_reg     <= b_mag;
                    neg_reg      <= a_neg ^ b_neg;
                    tag_hold_reg <= in_tag;
                    sum_reg      <= '0;
                    carry_reg    <= '0;
                    cnt_reg      <= '0;
                end
                ACCUM: begin
                    sum_reg   <= sum_next;
                    carry_reg <= carry_next;
                    a_sh_reg  <= a_sh_reg << PP_PER_CYCLE;
                    b_sh_reg  <= b_sh_reg >> PP_PER_CYCLE;
                    cnt_reg   <= cnt_reg + CNT_W'(1);
                end
                RESOLVE: if (!flush) begin
                    product_reg <= resolved;
                    tag_out_reg <= tag_hold_reg;
                end
                default: ;
            endcase
            if (flush) cnt_reg <= '0;
        end
    end
endmodule

// File: tb/tb_csa_seq_multiplier.sv
// Scoreboard bench: default 32-bit unit with directed/random ops, plus 8-bit sweep instances.
module tb_csa_seq_multiplier;
    localparam int W   = 32;
    localparam int TW  = 4;
    localparam int LAT = 9;

    logic              clk = 1'b0;
    logic              reset, flush, in_valid, in_signed, out_ready;
    logic [W-1:0]      in_a, in_b;
    logic [TW-1:0]     in_tag;
    logic              in_ready, out_valid, busy;
    logic [2*W-1:0]    out_product;
    logic [TW-1:0]     out_tag;

    always #5 clk = ~clk;

    csa_seq_multiplier #(.WIDTH(W), .PP_PER_CYCLE(4), .TAG_W(TW)) u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_tag(out_tag), .busy(busy)
    );

    // 8-bit instances with PP_PER_CYCLE = 1, 2, 8
    logic              sw_valid, sw_signed;
    logic [7:0]        sw_a, sw_b;
    logic [3:0]        sw_tag;
    logic [2:0]        sw_in_ready, sw_out_valid, sw_busy;
    logic [15:0]       sw_prod [3];
    logic [3:0]        sw_otag [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_sw
        localparam int PPG = (gi == 0) ? 1 : ((gi == 1) ? 2 : 8);
        csa_seq_multiplier #(.WIDTH(8), .PP_PER_CYCLE(PPG), .TAG_W(4)) u_sw (
            .clk(clk), .reset(reset), .flush(flush),
            .in_valid(sw_valid), .in_ready(sw_in_ready[gi]), .in_signed(sw_signed),
            .in_a(sw_a), .in_b(sw_b), .in_tag(sw_tag),
            .out_valid(sw_out_valid[gi]), .out_ready(1'b1),
            .out_product(sw_prod[gi]), .out_tag(sw_otag[gi]), .busy(sw_busy[gi])
        );
    end

    typedef struct packed {
        logic [63:0] prod;
        logic [3:0]  tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul32(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        ea = {{32{sgn & a[31]}}, a};
        eb = {{32{sgn & b[31]}}, b};
        return ea * eb;
    endfunction

    function automatic logic [15:0] ref_mul8(input logic sgn, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] ea, eb;
        ea = {{8{sgn & a[7]}}, a};
        eb = {{8{sgn & b[7]}}, b};
        return ea * eb;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        exp_t e;
        for (int k = 0; k < 50 && !in_ready; k++) step();
        check_eq("ready_before_issue", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_signed = sgn;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        step();
        in_valid = 1'b0;
        e.prod = ref_mul32(sgn, a, b);
        e.tag  = tag;
        sb_q.push_back(e);
        $display("issue signed=%0b a=0x%08h b=0x%08h tag=%0d", sgn, a, b, tag);
    endtask

    task automatic collect(input int hold, input bit flush_on_ack);
        int   k;
        exp_t e;
        k = 0;
        while (!out_valid && k < 40) begin
            step();
            k++;
        end
        check_eq("latency", 64'(k), 64'(LAT));
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: got output with no pending op, expected pending op");
            return;
        end
        e = sb_q.pop_front();
        check_eq("product", out_product, e.prod);
        check_eq("tag", 64'(out_tag), 64'(e.tag));
        $display("result product=0x%016h tag=%0d latency=%0d", out_product, out_tag, k);
        for (int i = 0; i < hold; i++) begin
            step();
            check_eq("hold_valid", 64'(out_valid), 64'd1);
            check_eq("hold_product", out_product, e.prod);
            check_eq("hold_tag", 64'(out_tag), 64'(e.tag));
            check_eq("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        flush     = flush_on_ack;
        step();
        out_ready = 1'b0;
        flush     = 1'b0;
        check_eq("ack_valid_drop", 64'(out_valid), 64'd0);
        check_eq("ack_in_ready", 64'(in_ready), 64'd1);
        check_eq("ack_busy", 64'(busy), 64'd0);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_out_valid"}, 64'(out_valid), 64'd0);
        check_eq({pfx, "_product"}, out_product, 64'd0);
        check_eq({pfx, "_tag"}, 64'(out_tag), 64'd0);
        check_eq({pfx, "_busy"}, 64'(busy), 64'd0);
        check_eq({pfx, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        bit          seen [3];
        logic [15:0] sw_exp;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_tag = '0;
        sw_valid = 1'b0; sw_signed = 1'b0; sw_a = '0; sw_b = '0; sw_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        step();

        // directed products
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5);
        collect(0, 1'b0);
        issue(1'b1, 32'h8000_0000, 32'h8000_0000, 4'd1);
        collect(0, 1'b0);
        issue(1'b1, 32'hFFFF_FFFD, 32'd7, 4'd2);
        collect(5, 1'b0);
        issue(1'b0, 32'hFFFF_FFFD, 32'd7, 4'd3);
        collect(0, 1'b0);

        // flush on the 4th ACCUM cycle, then a clean op
        issue(1'b0, 32'd123, 32'd456, 4'd4);
        repeat (3) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        void'(sb_q.pop_back());
        check_eq("flush_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 12; i++) begin
            step();
            check_eq("flush_no_valid", 64'(out_valid), 64'd0);
        end
        issue(1'b0, 32'd6, 32'd7, 4'd6);
        collect(0, 1'b0);

        // async reset mid-ACCUM, released between edges
        issue(1'b1, 32'h1234_5678, 32'hFEDC_BA98, 4'd9);
        step();
        step();
        #2 reset = 1'b1;
        #1 check_reset_outputs("async_reset");
        reset = 1'b0;
        void'(sb_q.pop_back());
        for (int i = 0; i < 12; i++) begin
            step();
            check_eq("post_reset_no_valid", 64'(out_valid), 64'd0);
        end

        // flush together with in_valid in IDLE: not accepted
        in_valid = 1'b1; flush = 1'b1; in_a = 32'd9; in_b = 32'd9; in_tag = 4'd8;
        step();
        in_valid = 1'b0; flush = 1'b0;
        check_eq("flush_accept_busy", 64'(busy), 64'd0);
        check_eq("flush_accept_ready", 64'(in_ready), 64'd1);

        // flush coinciding with the output handshake
        issue(1'b0, 32'd11, 32'd13, 4'd7);
        collect(0, 1'b1);

        // random ops with random backpressure, edge operands mixed in
        for (int n = 0; n < 20; n++) begin
            rs = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
            issue(rs, ra, rb, 4'($urandom_range(0, 15)));
            collect($urandom_range(0, 2), 1'b0);
        end

        // 8-bit sweep across PP_PER_CYCLE = 1, 2, 8
        for (int n = 0; n < 30; n++) begin
            sw_signed = 1'($urandom_range(0, 1));
            sw_a      = 8'($urandom);
            sw_b      = 8'($urandom);
            sw_tag    = 4'($urandom);
            sw_exp    = ref_mul8(sw_signed, sw_a, sw_b);
            check_eq("sw_ready", 64'(sw_in_ready), 64'd7);
            sw_valid = 1'b1;
            step();
            sw_valid = 1'b0;
            for (int j = 0; j < 3; j++) seen[j] = 1'b0;
            for (int k = 1; k <= 12; k++) begin
                step();
                for (int j = 0; j < 3; j++) begin
                    if (sw_out_valid[j] && !seen[j]) begin
                        seen[j] = 1'b1;
                        check_eq("sw_latency", 64'(k), 64'((j == 0) ? 9 : ((j == 1) ? 5 : 2)));
                        check_eq("sw_product", 64'(sw_prod[j]), 64'(sw_exp));
                        check_eq("sw_tag", 64'(sw_otag[j]), 64'(sw_tag));
                    end
                end
            end
            for (int j = 0; j < 3; j++) check_eq("sw_seen", 64'(seen[j]), 64'd1);
            check_eq("sw_idle", 64'(sw_busy), 64'd0);
            $display("sweep signed=%0b a=0x%02h b=0x%02h expected=0x%04h", sw_signed, sw_a, sw_b, sw_exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/csa_seq_multiplier.md
Name: csa_seq_multiplier

Overview:
- Multi-cycle, parametrised multiply functional unit for the Tomasulo datapath.
- Accepts one operation at a time from its reservation station, carrying a tag.
- Each cycle it reduces PP_PER_CYCLE partial products into a carry-save accumulator (sum/carry pair, 3:2 compressor chain), then resolves with one carry-propagate add.
- Presents the tagged 2*WIDTH product to the CDB arbiter under a valid/ready handshake; supports signed/unsigned modes and pipeline flush.

Parameters:
- WIDTH, 32, operand width in bits; even, ≥4.
- PP_PER_CYCLE, 4, partial products folded per accumulate cycle; power of two, divides WIDTH.
- TAG_W, 4, reservation-station tag width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous kill of any in-flight or held operation.
- in_valid  input  1  operation offered.
- in_ready  output  1  unit can accept an operation.
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- in_tag  input  TAG_W  reservation-station tag.
- out_valid  output  1  product available.
- out_ready  input  1  CDB grant.
- out_product  output  2*WIDTH  full product.
- out_tag  output  TAG_W  tag of the product.
- busy  output  1  state is not IDLE.

Behaviour:
- ITER = WIDTH/PP_PER_CYCLE.
- States:
  - IDLE: in_ready=1.
  - ACCUM: ITER cycles.
  - RESOLVE: 1 cycle.
  - DONE: out_valid=1.
- Reset (async): state=IDLE; accumulators and counter zeroed.
  - out_valid=0, out_product=0, out_tag=0, busy=0, in_ready=1.
- Accept: in_valid & in_ready at a clock edge.
  - Operands are latched.
  - Signed mode: magnitudes |a|, |b| are latched along with neg = a_sign XOR b_sign.
  - Unsigned mode: neg = 0.
  - Magnitudes are WIDTH+1 bits wide internally, so −2^(WIDTH−1) is handled.
  - State goes to ACCUM.
- ACCUM: each cycle, PP_PER_CYCLE shifted partial products (|a| AND b-bit, weighted by bit index) plus the sum/carry pair pass through a 3:2 CSA tree.
  - No carry propagation across the word during ACCUM.
  - The counter increments each cycle; after ITER cycles, state goes to RESOLVE.
- RESOLVE: product = sum + carry (CPA), negated if neg; result and tag are registered; state goes to DONE.
- Latency: out_valid rises exactly ITER+1 edges after the accept edge (9 for defaults).
- DONE: out_product and out_tag are held stable while out_valid=1 and out_ready=0, for any number of cycles.
  - On out_valid & out_ready: state goes to IDLE, and out_valid drops at that edge.
  - No same-cycle re-accept; in_ready is 1 the following cycle.
  - Peak throughput is one op per ITER+3 cycles.
- in_ready is 0 in ACCUM, RESOLVE and DONE; in_valid is ignored there.
- flush (synchronous, highest priority): state goes to IDLE; out_valid=0 next cycle; counter is cleared.
  - flush in the same cycle as in_valid & in_ready: the operation is not accepted.
  - flush in the same cycle as an out handshake: the handshake still counts as completed, and the state is IDLE either way.
- Reset mid-operation: immediate return to the reset state; no output is produced.
- Width rule: the product is exact for all inputs; overflow cannot occur in 2*WIDTH bits.
- out_product and out_tag hold their last value outside DONE; they are only meaningful while out_valid=1.

Test Plan:
- Unsigned, WIDTH=32: a=0xFFFFFFFF, b=0xFFFFFFFF, tag=5 → out_valid exactly 9 edges after accept; product=0xFFFFFFFE00000001, tag=5.
- Signed: a=0x80000000, b=0x80000000 → 0x4000000000000000. Signed: a=−3, b=7 → 0xFFFFFFFFFFFFFFEB. Unsigned with the same bits as −3 and 7: a=0xFFFFFFFD, b=7 → 0x00000006FFFFFFEB.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → product and tag stable and in_ready=0 throughout. Then raise out_ready → out_valid=0 and in_ready=1 next cycle.
- Flush on the 4th ACCUM cycle → out_valid never asserts. Next op a=6, b=7 accepted → product=42 after 9 edges; no stale data.
- Async reset mid-ACCUM, released between edges → all outputs at reset values immediately. Flush asserted together with in_valid in IDLE → op not accepted, busy stays 0.
- Parameter sweep WIDTH=8, PP_PER_CYCLE∈{1,2,8}: random signed/unsigned ops vs. reference model → latency ITER+1 and exact product.
